// File: rtl/mnist_img_loader_pkg.sv
// ---------------------------------------------------------------------------
// mnist_pkg
// Shared constants, state encoding and helpers for the MNIST image loader.
//   N_PIX     : pixels per image (28x28)
//   PIX_W     : pixel width in bits
//   N_CLASS   : width of the classifier core's one-hot output
//   CLASS_ERR : class index reported when the result is unusable
// ---------------------------------------------------------------------------
package mnist_pkg;

  localparam int N_PIX   = 784;
  localparam int PIX_W   = 8;
  localparam int N_CLASS = 10;

  localparam logic [3:0] CLASS_ERR = 4'hF;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HOLD   = 2'd1,
    RESULT = 2'd2
  } state_t;

  // Saturating 16-bit increment used by the cycle counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return 16'hFFFF;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/mnist_img_loader_onehot_dec.sv
// ---------------------------------------------------------------------------
// mnist_onehot_dec
// Combinational one-hot to class-index decoder.
//   onehot : N_CLASS-bit one-hot class vector from the core
//   idx    : index of the set bit, CLASS_ERR when not exactly one bit is set
//   err    : high when zero or more than one bit is set
// ---------------------------------------------------------------------------
module mnist_onehot_dec
  import mnist_pkg::*;
(
  input  logic [N_CLASS-1:0] onehot,
  output logic [3:0]         idx,
  output logic               err
);

  logic [3:0] found_s;
  logic [3:0] ones_s;

  // Count set bits and remember the position of the last one seen.
  always_comb begin
    found_s = 4'd0;
    ones_s  = 4'd0;
    for (int k = 0; k < N_CLASS; k++) begin
      if (onehot[k]) begin
        found_s = 4'(k);
        ones_s  = ones_s + 4'd1;
      end else begin
        found_s = found_s;
        ones_s  = ones_s;
      end
    end
  end

  // A usable result has exactly one bit set; otherwise report CLASS_ERR.
  always_comb begin
    if (ones_s == 4'd1) begin
      err = 1'b0;
      idx = found_s;
    end else begin
      err = 1'b1;
      idx = CLASS_ERR;
    end
  end

endmodule

// File: rtl/mnist_img_loader.sv
// ---------------------------------------------------------------------------
// mnist_img_loader
// Deserialises a byte-wide raster pixel stream into the parallel image bus of
// the MNIST classifier core, holds it stable for NET_LAT cycles, captures the
// core's one-hot result and returns it as a class index over valid/ready.
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   pix_valid/data/last     : pixel stream in, pix_ready back-pressure out
//   img_data[0..N_PIX-1]    : image bus to the core
//   net_out                 : core one-hot output
//   res_valid/class/err     : result out, res_ready from consumer
//   busy                    : image in progress or result outstanding
//   perf_cycles             : cycles from first pixel to result (optional)
//
// Build option: define MNIST_IMG_LOADER_PERF_EN to add the perf_cycles output
// and its saturating 16-bit counter.
// ---------------------------------------------------------------------------
module mnist_img_loader
  import mnist_pkg::*;
#(
  parameter int NET_LAT = 4
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   pix_data,
  input  logic               pix_last,
  output logic               pix_ready,
  output logic [PIX_W-1:0]   img_data [N_PIX],
  input  logic [N_CLASS-1:0] net_out,
  output logic               res_valid,
  output logic [3:0]         res_class,
  output logic               res_err,
  input  logic               res_ready,
`ifdef MNIST_IMG_LOADER_PERF_EN
  output logic [15:0]        perf_cycles,
`endif
  output logic               busy
);

  localparam int CNT_W  = $clog2(N_PIX);
  localparam int WAIT_W = (NET_LAT < 2) ? 1 : $clog2(NET_LAT);

  state_t            state_r;
  logic [CNT_W-1:0]  pix_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              align_err_r;

  logic              last_beat_s;
  logic              accept_s;
  logic              wait_done_s;
  logic [3:0]        dec_idx_s;
  logic              dec_err_s;

  assign last_beat_s = (pix_cnt_r == CNT_W'(N_PIX - 1));
  assign accept_s    = pix_valid && pix_ready;
  assign wait_done_s = (wait_cnt_r == WAIT_W'(NET_LAT - 1));

  mnist_onehot_dec u_dec (
    .onehot (net_out),
    .idx    (dec_idx_s),
    .err    (dec_err_s)
  );

  // Loader state machine; every output is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= FILL;
      pix_cnt_r   <= {CNT_W{1'b0}};
      wait_cnt_r  <= {WAIT_W{1'b0}};
      align_err_r <= 1'b0;
      pix_ready   <= 1'b1;
      res_valid   <= 1'b0;
      res_class   <= 4'd0;
      res_err     <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < N_PIX; i++) begin
        img_data[i] <= {PIX_W{1'b0}};
      end
    end else begin
      case (state_r)
        FILL: begin
          if (accept_s) begin
            img_data[pix_cnt_r] <= pix_data;
            busy                <= 1'b1;
            // pix_last must coincide with the final index; a mismatch is
            // remembered but the image still completes on count alone.
            if (pix_last != last_beat_s) begin
              align_err_r <= 1'b1;
            end else begin
              align_err_r <= align_err_r;
            end
            if (last_beat_s) begin
              state_r    <= HOLD;
              pix_cnt_r  <= {CNT_W{1'b0}};
              wait_cnt_r <= {WAIT_W{1'b0}};
              pix_ready  <= 1'b0;
            end else begin
              pix_cnt_r  <= pix_cnt_r + CNT_W'(1);
            end
          end else begin
            pix_ready <= 1'b1;
          end
        end
        HOLD: begin
          // net_out is sampled on the NET_LAT-th edge after the last pixel.
          if (wait_done_s) begin
            res_class <= dec_idx_s;
            res_err   <= dec_err_s | align_err_r;
            res_valid <= 1'b1;
            state_r   <= RESULT;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            align_err_r <= 1'b0;
            pix_ready   <= 1'b1;
            busy        <= 1'b0;
            state_r     <= FILL;
          end else begin
            res_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= FILL;
          pix_cnt_r <= {CNT_W{1'b0}};
          pix_ready <= 1'b1;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef MNIST_IMG_LOADER_PERF_EN
  logic [15:0] perf_cnt_r;

  // Cycle counter: 1 on the first accepted pixel, then every cycle until the
  // result is captured; the value including that final edge is latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_r  <= 16'd0;
      perf_cycles <= 16'd0;
    end else begin
      if (state_r == FILL && accept_s && pix_cnt_r == {CNT_W{1'b0}}) begin
        perf_cnt_r <= 16'd1;
      end else if (state_r == HOLD ||
                   (state_r == FILL && pix_cnt_r != {CNT_W{1'b0}})) begin
        perf_cnt_r <= sat_inc16(perf_cnt_r);
      end else begin
        perf_cnt_r <= perf_cnt_r;
      end
      if (state_r == HOLD && wait_done_s) begin
        perf_cycles <= sat_inc16(perf_cnt_r);
      end else begin
        perf_cycles <= perf_cycles;
      end
    end
  end
`else
  // No cycle counter in this build.
`endif

endmodule

// File: tb/tb_mnist_img_loader.sv
// ---------------------------------------------------------------------------
// tb_mnist_img_loader
// Directed self-checking bench for mnist_img_loader.
// ---------------------------------------------------------------------------
module tb_mnist_img_loader;

  localparam int NET_LAT = 4;
  localparam int NPIX    = 784;

  logic        clk;
  logic        rst_n;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_last;
  logic        pix_ready;
  logic [7:0]  img_data [784];
  logic [9:0]  net_out;
  logic        res_valid;
  logic [3:0]  res_class;
  logic        res_err;
  logic        res_ready;
  logic        busy;
`ifdef MNIST_IMG_LOADER_PERF_EN
  logic [15:0] perf_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mnist_img_loader #(.NET_LAT(NET_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_last   (pix_last),
    .pix_ready  (pix_ready),
    .img_data   (img_data),
    .net_out    (net_out),
    .res_valid  (res_valid),
    .res_class  (res_class),
    .res_err    (res_err),
    .res_ready  (res_ready),
`ifdef MNIST_IMG_LOADER_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .busy       (busy)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Streams n_beats pixels (value = index + off), pix_last on last_idx.
  // Returns on the falling edge after the final accepted beat.
  task automatic load_image(input int n_beats, input int last_idx,
                            input int off, input bit gap);
    for (int i = 0; i < n_beats; i++) begin
      int guard;
      guard = 0;
      @(negedge clk);
      pix_valid = 1'b1;
      pix_data  = 8'(i + off);
      pix_last  = (i == last_idx);
      while (!pix_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!pix_ready) begin
        check_eq("pix_ready_timeout", 32'(pix_ready), 32'd1);
        break;
      end
      @(posedge clk);
      if (gap && i != n_beats - 1) begin
        @(negedge clk);
        pix_valid = 1'b0;
      end
    end
    @(negedge clk);
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("res_valid_timeout", 32'(res_valid), 32'd1);
  endtask

  // Completes the handshake and checks the loader is ready again.
  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_eq("hs_res_valid", 32'(res_valid), 32'd0);
    check_eq("hs_pix_ready", 32'(pix_ready), 32'd1);
    check_eq("hs_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 8'd0;
    pix_last  = 1'b0;
    net_out   = 10'd0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    check_eq("rst_pix_ready", 32'(pix_ready), 32'd1);
    check_eq("rst_res_valid", 32'(res_valid), 32'd0);
    check_eq("rst_res_class", 32'(res_class), 32'd0);
    check_eq("rst_res_err", 32'(res_err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_img0", 32'(img_data[0]), 32'd0);
`ifdef MNIST_IMG_LOADER_PERF_EN
    check_eq("rst_perf", 32'(perf_cycles), 32'd0);
`endif
    rst_n = 1'b1;

    // 1: clean image, class 3, exact latency.
    net_out = 10'b0000001000;
    load_image(NPIX, NPIX - 1, 0, 1'b0);
    check_eq("t1_pix_ready_drop", 32'(pix_ready), 32'd0);
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_res_valid_e0", 32'(res_valid), 32'd0);
    repeat (NET_LAT - 1) @(negedge clk);
    check_eq("t1_res_valid_early", 32'(res_valid), 32'd0);
    @(negedge clk);
    check_eq("t1_res_valid", 32'(res_valid), 32'd1);
    check_eq("t1_res_class", 32'(res_class), 32'd3);
    check_eq("t1_res_err", 32'(res_err), 32'd0);
    check_eq("t1_img0", 32'(img_data[0]), 32'd0);
    check_eq("t1_img1", 32'(img_data[1]), 32'd1);
    check_eq("t1_img255", 32'(img_data[255]), 32'd255);
    check_eq("t1_img256", 32'(img_data[256]), 32'd0);
    check_eq("t1_img783", 32'(img_data[783]), 32'd15);
    handshake();

    // 2: result held under back-pressure for 20 cycles.
    net_out = 10'b0000000100;
    load_image(NPIX, NPIX - 1, 0, 1'b0);
    wait_result();
    for (int c = 0; c < 20; c++) begin
      check_eq("t2_res_valid", 32'(res_valid), 32'd1);
      check_eq("t2_res_class", 32'(res_class), 32'd2);
      check_eq("t2_pix_ready", 32'(pix_ready), 32'd0);
      @(negedge clk);
      net_out = 10'b0000010000;
    end
    handshake();

    // 3: not one-hot.
    net_out = 10'b0000000000;
    load_image(NPIX, NPIX - 1, 0, 1'b0);
    wait_result();
    check_eq("t3a_res_class", 32'(res_class), 32'hF);
    check_eq("t3a_res_err", 32'(res_err), 32'd1);
    handshake();
    net_out = 10'b1000000001;
    load_image(NPIX, NPIX - 1, 0, 1'b0);
    wait_result();
    check_eq("t3b_res_class", 32'(res_class), 32'hF);
    check_eq("t3b_res_err", 32'(res_err), 32'd1);
    handshake();

    // 4: early pix_last, then a clean image clears the flag.
    net_out = 10'b1000000000;
    load_image(NPIX, 500, 0, 1'b0);
    check_eq("t4_img783", 32'(img_data[783]), 32'd15);
    wait_result();
    check_eq("t4_res_class", 32'(res_class), 32'd9);
    check_eq("t4_res_err", 32'(res_err), 32'd1);
    handshake();
    load_image(NPIX, NPIX - 1, 0, 1'b0);
    wait_result();
    check_eq("t4c_res_class", 32'(res_class), 32'd9);
    check_eq("t4c_res_err", 32'(res_err), 32'd0);
    handshake();

    // 5: asynchronous reset during HOLD and mid-image.
    net_out = 10'b0000000010;
    load_image(NPIX, NPIX - 1, 0, 1'b0);
    check_eq("t5_busy_hold", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5a_pix_ready", 32'(pix_ready), 32'd1);
    check_eq("t5a_res_valid", 32'(res_valid), 32'd0);
    check_eq("t5a_busy", 32'(busy), 32'd0);
    check_eq("t5a_img5", 32'(img_data[5]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load_image(300, -1, 0, 1'b0);
    check_eq("t5_busy_partial", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5b_busy", 32'(busy), 32'd0);
    check_eq("t5b_pix_ready", 32'(pix_ready), 32'd1);
    check_eq("t5b_img10", 32'(img_data[10]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    net_out = 10'b0010000000;
    load_image(NPIX, NPIX - 1, 100, 1'b0);
    wait_result();
    check_eq("t5c_img0", 32'(img_data[0]), 32'd100);
    check_eq("t5c_img783", 32'(img_data[783]), 32'd115);
    check_eq("t5c_res_class", 32'(res_class), 32'd7);
    check_eq("t5c_res_err", 32'(res_err), 32'd0);
    handshake();

`ifdef MNIST_IMG_LOADER_PERF_EN
    // 6: gapped stream, cycle counter.
    net_out = 10'b0000000001;
    load_image(NPIX, NPIX - 1, 0, 1'b1);
    wait_result();
    check_eq("t6_res_class", 32'(res_class), 32'd0);
    check_eq("t6_perf", 32'(perf_cycles), 32'(2 * NPIX - 1 + NET_LAT));
    handshake();
    check_eq("t6_perf_held", 32'(perf_cycles), 32'(2 * NPIX - 1 + NET_LAT));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
